// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  function automatic int nchunk(int width, int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Index register must stay at least one bit wide even for a single chunk.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle between the adder and its producer/consumer.
interface seq_chunk_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder; also exposes the carry into its top bit for overflow detection.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [CHUNK:0] full;

  assign full     = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign s        = full[CHUNK-1:0];
  assign co       = full[CHUNK];
  // The sum bit is x^y^carry_in, so the incoming carry falls out by xor-ing it back.
  assign c_msb_in = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple adder: WIDTH-bit a+b+cin computed CHUNK bits per clock through one shared adder.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [NCHUNK-1:0][CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic [CHUNK-1:0] x, y, cs;
  logic             co, cmsb, last_co, last_ci;

  // Zero-pad operands to a whole number of chunks.
  assign a_ch = PW'(a_q);
  assign b_ch = PW'(b_q);
  assign x    = a_ch[idx_q];
  assign y    = b_ch[idx_q];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x        (x),
    .y        (y),
    .ci       (carry_q),
    .s        (cs),
    .co       (co),
    .c_msb_in (cmsb)
  );

  // With a partial last chunk, the true MSB sits at bit LASTW-1 of that chunk.
  if (LASTW == CHUNK) begin : g_full_last
    assign last_co = co;
    assign last_ci = cmsb;
  end else begin : g_part_last
    logic unused_cmsb;
    assign unused_cmsb = cmsb;
    assign last_co     = cs[LASTW];
    assign last_ci     = x[LASTW-1] ^ y[LASTW-1] ^ cs[LASTW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    ovf_d         = ovf_q;
    sum_ch        = PW'(sum_q);
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_ch[idx_q] = cs;
        sum_d         = WIDTH'(sum_ch);
        carry_d       = co;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = last_co;
          ovf_d   = last_ci ^ last_co;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Retiring and accepting share one edge so back-to-back adds have no bubble.
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            idx_d   = '0;
            state_d = ADD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed corner cases on W16/C4 and W10/C4 plus a random sweep of shapes.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit sweep_go = 1'b0;

  typedef struct packed { logic ovf; logic cout; logic [63:0] sum; } model_t;

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic model_t ref_add(int w, logic [63:0] a, logic [63:0] b, logic cin);
    model_t m;
    logic [64:0] full;
    full   = {1'b0, a} + {1'b0, b} + 65'(cin);
    m.sum  = full[63:0] & ((64'd1 << w) - 64'd1);
    m.cout = full[w];
    m.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return m;
  endfunction

  seq_chunk_adder_if #(.WIDTH(16)) bus16();
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  seq_chunk_adder_if #(.WIDTH(10)) bus10();
  seq_chunk_adder #(.WIDTH(10), .CHUNK(4)) u10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));

  // Random sweep shapes: W in {1,8,13,32}, C in {1,3,W} (C clipped to W).
  localparam int NSW = 10;
  localparam int SW [NSW] = '{1, 8, 8, 8, 13, 13, 13, 32, 32, 32};
  localparam int SC [NSW] = '{1, 1, 3, 8, 1, 3, 13, 1, 3, 32};
  logic [NSW-1:0] sweep_done;

  for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
    localparam int W = SW[gi];
    localparam int C = SC[gi];
    localparam int N = (W + C - 1) / C;
    bit done = 1'b0;
    seq_chunk_adder_if #(.WIDTH(W)) bus();
    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign sweep_done[gi] = done;

    initial begin
      logic [W-1:0] ra, rb;
      logic rc;
      model_t m;
      int lat, g;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      wait (sweep_go);
      for (int it = 0; it < 24; it++) begin
        ra = W'($urandom()); rb = W'($urandom()); rc = 1'($urandom());
        if (it == 0) begin ra = '1; rb = '0; rc = 1'b1; end
        if (it == 1) begin ra = '1; rb = '1; rc = 1'b1; end
        m = ref_add(W, 64'(ra), 64'(rb), rc);
        @(negedge clk);
        bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = W'($urandom()); bus.b = W'($urandom()); bus.cin = ~rc;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== N || bus.sum !== m.sum[W-1:0] || bus.cout !== m.cout || bus.ovf !== m.ovf) begin
          n_fail++;
          $display("FAIL sweep W%0d/C%0d: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=%0d sum=%h cout=%b ovf=%b",
                   W, C, lat, bus.sum, bus.cout, bus.ovf, N, m.sum[W-1:0], m.cout, m.ovf);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
    int g;
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
    g = 0;
    while (!bus16.in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0; bus16.a = 16'($urandom()); bus16.b = 16'($urandom()); bus16.cin = ~cin;
    lat = 0;
    while (!bus16.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic issue10(input logic [9:0] a, input logic [9:0] b, input logic cin, output int lat);
    int g;
    @(negedge clk);
    bus10.a = a; bus10.b = b; bus10.cin = cin; bus10.in_valid = 1'b1; bus10.out_ready = 1'b0;
    g = 0;
    while (!bus10.in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus10.in_valid = 1'b0; bus10.a = 10'($urandom()); bus10.b = 10'($urandom()); bus10.cin = ~cin;
    lat = 0;
    while (!bus10.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic retire16();
    @(negedge clk); bus16.out_ready = 1'b1;
    @(posedge clk); #1; bus16.out_ready = 1'b0;
  endtask

  task automatic retire10();
    @(negedge clk); bus10.out_ready = 1'b1;
    @(posedge clk); #1; bus10.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset16: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected 1 0 0000 0 0",
               bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    n_checks++;
    if ({bus10.in_ready, bus10.out_valid, bus10.sum, bus10.cout, bus10.ovf} !== {1'b1, 1'b0, 10'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset10: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected 1 0 000 0 0",
               bus10.in_ready, bus10.out_valid, bus10.sum, bus10.cout, bus10.ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    int lat;
    issue16(16'hFFFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL latency16: got %0d cycles, expected 4", lat); end
    n_checks++;
    if ({bus16.sum, bus16.cout, bus16.ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_chain: got sum=%h cout=%b ovf=%b, expected 0000 1 0", bus16.sum, bus16.cout, bus16.ovf);
    end
    retire16();
  endtask

  task automatic test_signed_ovf();
    logic [15:0] ta [2] = '{16'h7FFF, 16'h8000};
    logic [15:0] tb [2] = '{16'h0001, 16'h8000};
    logic [15:0] es [2] = '{16'h8000, 16'h0000};
    logic        ec [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue16(ta[i], tb[i], 1'b0, lat);
      n_checks++;
      if ({bus16.sum, bus16.cout, bus16.ovf} !== {es[i], ec[i], 1'b1}) begin
        n_fail++;
        $display("FAIL signed_ovf[%0d]: got sum=%h cout=%b ovf=%b, expected %h %b 1",
                 i, bus16.sum, bus16.cout, bus16.ovf, es[i], ec[i]);
      end
      retire16();
    end
  endtask

  task automatic test_partial_chunk();
    logic [9:0] ta [2] = '{10'h3FF, 10'h1FF};
    logic [9:0] tb [2] = '{10'h000, 10'h001};
    logic       tc [2] = '{1'b1, 1'b0};
    logic [9:0] es [2] = '{10'h000, 10'h200};
    logic       ec [2] = '{1'b1, 1'b0};
    logic       eo [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue10(ta[i], tb[i], tc[i], lat);
      n_checks++;
      if (lat !== 3 || {bus10.sum, bus10.cout, bus10.ovf} !== {es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL partial_chunk[%0d]: got lat=%0d sum=%h cout=%b ovf=%b, expected 3 %h %b %b",
                 i, lat, bus10.sum, bus10.cout, bus10.ovf, es[i], ec[i], eo[i]);
      end
      retire10();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ra, rb;
    logic rc;
    model_t m;
    int lat;
    ra = 16'($urandom()); rb = 16'($urandom()); rc = 1'($urandom());
    m = ref_add(16, 64'(ra), 64'(rb), rc);
    issue16(ra, rb, rc, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.a = 16'($urandom()); bus16.b = 16'($urandom());
      #1;
      n_checks++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.sum !== m.sum[15:0] ||
          bus16.cout !== m.cout || bus16.ovf !== m.ovf) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b, expected 1 0 %h %b %b",
                 k, bus16.out_valid, bus16.in_ready, bus16.sum, bus16.cout, bus16.ovf, m.sum[15:0], m.cout, m.ovf);
      end
    end
    @(negedge clk); bus16.in_valid = 1'b0;
    retire16();
    n_checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_to_idle: got vld=%b rdy=%b, expected 0 1", bus16.out_valid, bus16.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa [3], qb [3];
    logic        qc [3];
    model_t m;
    int acc, got, cyc, gap;
    bit took;
    for (int i = 0; i < 3; i++) begin
      qa[i] = 16'($urandom()); qb[i] = 16'($urandom()); qc[i] = 1'($urandom());
    end
    @(negedge clk);
    bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
    bus16.a = qa[0]; bus16.b = qb[0]; bus16.cin = qc[0];
    acc = 0; got = 0; cyc = 0; gap = 0;
    while (got < 3 && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      took = bus16.in_valid && bus16.in_ready;
      if (bus16.out_valid) begin
        m = ref_add(16, 64'(qa[got]), 64'(qb[got]), qc[got]);
        n_checks++;
        if (bus16.sum !== m.sum[15:0] || bus16.cout !== m.cout || bus16.ovf !== m.ovf) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b, expected %h %b %b",
                   got, bus16.sum, bus16.cout, bus16.ovf, m.sum[15:0], m.cout, m.ovf);
        end
        // Between results only the NCHUNK add cycles may show out_valid low.
        if (got > 0) begin
          n_checks++;
          if (gap !== 4) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles, expected 4", got, gap); end
        end
        got++; gap = 0;
      end else if (acc > 0) gap++;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        if (acc < 3) begin bus16.a = qa[acc]; bus16.b = qb[acc]; bus16.cin = qc[acc]; end
        else bus16.in_valid = 1'b0;
      end
    end
    n_checks++;
    if (got !== 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d results, expected 3", got); end
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_add();
    logic [15:0] ra, rb;
    logic rc;
    model_t m;
    int lat, seen;
    @(negedge clk);
    bus16.a = 16'h1234; bus16.b = 16'h0101; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk); #1; bus16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_add: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected 1 0 0000 0 0",
               bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (bus16.out_valid) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles, expected 0", seen); end
    ra = 16'($urandom()); rb = 16'($urandom()); rc = 1'($urandom());
    m = ref_add(16, 64'(ra), 64'(rb), rc);
    issue16(ra, rb, rc, lat);
    n_checks++;
    if (lat !== 4 || bus16.sum !== m.sum[15:0] || bus16.cout !== m.cout || bus16.ovf !== m.ovf) begin
      n_fail++;
      $display("FAIL after_reset_add: got lat=%0d sum=%h cout=%b ovf=%b, expected 4 %h %b %b",
               lat, bus16.sum, bus16.cout, bus16.ovf, m.sum[15:0], m.cout, m.ovf);
    end
    retire16();
  endtask

  task automatic test_random_sweep();
    int g;
    sweep_go = 1'b1;
    g = 0;
    while (sweep_done !== '1 && g < 20000) begin @(posedge clk); g++; end
    n_checks++;
    if (sweep_done !== '1) begin
      n_fail++;
      $display("FAIL sweep_timeout: got done=%b, expected all ones", sweep_done);
    end
  endtask

  initial begin
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus10.in_valid = 1'b0; bus10.out_ready = 1'b0; bus10.a = '0; bus10.b = '0; bus10.cin = 1'b0;
    test_reset();
    test_carry_chain();
    test_signed_ovf();
    test_partial_chunk();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
